// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// mem_access_ctrl : load/store/fetch sequencer between a request port and a
//                   single-cycle-strobed memory with ack handshake.
// Optional timeout feature: define MEM_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module mem_access_ctrl #(
    parameter int DATA_BUS_WIDTH    = 16,
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int TIMEOUT_CYCLES    = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic                         req_fetch,
    input  logic [ADDRESS_BUS_WIDTH-1:0] req_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    req_wdata,
    output logic [ADDRESS_BUS_WIDTH-1:0] mem_addr,
    output logic [DATA_BUS_WIDTH-1:0]    mem_wdata,
    output logic                         mem_rd,
    output logic                         mem_wr,
    input  logic [DATA_BUS_WIDTH-1:0]    mem_rdata,
    input  logic                         mem_ack,
    output logic                         mar_en,
    output logic                         mdr_en,
    output logic                         ir_en,
    output logic [DATA_BUS_WIDTH-1:0]    rsp_data,
    output logic                         rsp_valid,
    output logic                         rsp_err
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [ADDRESS_BUS_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_BUS_WIDTH-1:0]      wdata_q, wdata_d;
    logic [DATA_BUS_WIDTH-1:0]      rdata_q, rdata_d;
    logic                           write_q, write_d;
    logic                           fetch_q, fetch_d;
    logic                           err_flag;

`ifdef MEM_TIMEOUT_EN
    logic [7:0]                     cnt_q, cnt_d;
    logic                           err_q, err_d;
    assign err_flag = err_q;
`else
    assign err_flag = 1'b0;
`endif

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rsp_data  = rdata_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        write_d   = write_q;
        fetch_d   = fetch_q;
        req_ready = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mar_en    = 1'b0;
        mdr_en    = 1'b0;
        ir_en     = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    fetch_d = req_fetch & ~req_write;
`ifdef MEM_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = ADDR;
                end
            end
            ADDR: begin
                mar_en = 1'b1;
                mem_rd = ~write_q;
                mem_wr = write_q;
`ifdef MEM_TIMEOUT_EN
                cnt_d  = 8'd0;
`endif
                if (mem_ack) begin
                    if (!write_q) rdata_d = mem_rdata;
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                mem_rd = ~write_q;
                mem_wr = write_q;
                if (mem_ack) begin
                    if (!write_q) rdata_d = mem_rdata;
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 8'd1;
                    // The cycle whose increment reaches the limit is the last one waited.
                    if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
`endif
            end
            DONE: begin
                rsp_valid = 1'b1;
                rsp_err   = err_flag;
                if (!write_q && !err_flag) begin
                    ir_en  = fetch_q;
                    mdr_en = ~fetch_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            fetch_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            write_q <= write_d;
            fetch_q <= fetch_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// tb_mem_access_ctrl : table-driven directed bench for mem_access_ctrl.
module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 15;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_fetch;
    logic [15:0] req_addr, req_wdata, mem_addr, mem_wdata, mem_rdata, rsp_data;
    logic        mem_rd, mem_wr, mem_ack, mar_en, mdr_en, ir_en, rsp_valid, rsp_err;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(
        .DATA_BUS_WIDTH(16), .ADDRESS_BUS_WIDTH(16), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_fetch(req_fetch), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mar_en(mar_en), .mdr_en(mdr_en), .ir_en(ir_en),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        write;
        logic        fetch;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          delay;     // cycles after ADDR before ack; >= 40 means never
        logic [15:0] rdata;
        int          exp_lat;
        int          exp_strobes;
        logic        exp_ir;
        logic        exp_mdr;
        logic        exp_err;
        logic [15:0] exp_rsp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   lat = 0;
        int   strobes = 0;
        logic bad_strobe = 1'b0;
        logic bad_addr = 1'b0;
        logic mar_ok = 1'b0;
        @(negedge clk);
        chk({v.name, " ready"}, req_ready, 1);
        req_valid = 1'b1; req_write = v.write; req_fetch = v.fetch;
        req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = ~v.addr; req_wdata = ~v.wdata;
        req_write = ~v.write; req_fetch = ~v.fetch;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            mem_ack   = (c == 1 + v.delay);
            mem_rdata = mem_ack ? v.rdata : 16'hDEAD;
            if (c == 1) mar_ok = mar_en;
            else if (mar_en) bad_strobe = 1'b1;
            if (mem_rd || mem_wr) begin
                strobes++;
                if ((mem_rd && mem_wr) || (mem_wr != v.write)) bad_strobe = 1'b1;
            end
            if (mem_addr !== v.addr || (v.write && mem_wdata !== v.wdata)) bad_addr = 1'b1;
            if (rsp_valid) begin
                lat = c;
                chk({v.name, " ir_en"},    ir_en,    v.exp_ir);
                chk({v.name, " mdr_en"},   mdr_en,   v.exp_mdr);
                chk({v.name, " rsp_err"},  rsp_err,  v.exp_err);
                chk({v.name, " rsp_data"}, rsp_data, v.exp_rsp);
            end
        end
        mem_ack = 1'b0;
        chk({v.name, " mar_en"},   mar_ok,     1);
        chk({v.name, " latency"},  lat,        v.exp_lat);
        chk({v.name, " strobes"},  strobes,    v.exp_strobes);
        chk({v.name, " strobe_ok"}, bad_strobe, 0);
        chk({v.name, " addr_data_stable"}, bad_addr, 0);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_fetch = 1'b0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;

        //        name        wr fe addr     wdata    dly rdata    lat str ir mdr err rsp
        tbl.push_back('{"fetch",  0, 1, 16'h0040, 16'h0000, 0, 16'hA5A5, 2, 1, 1, 0, 0, 16'hA5A5});
        tbl.push_back('{"store",  1, 0, 16'h00FF, 16'h1234, 3, 16'h0000, 5, 4, 0, 0, 0, 16'hA5A5});
        tbl.push_back('{"load1",  0, 0, 16'h1000, 16'h0000, 1, 16'h5A5A, 3, 2, 0, 1, 0, 16'h5A5A});
        tbl.push_back('{"storef", 1, 1, 16'hFFFF, 16'hBEEF, 0, 16'h0000, 2, 1, 0, 0, 0, 16'h5A5A});
        tbl.push_back('{"load2",  0, 0, 16'h0002, 16'h0000, 2, 16'h0F0F, 4, 3, 0, 1, 0, 16'h0F0F});
`ifdef MEM_TIMEOUT_EN
        tbl.push_back('{"tmo",    0, 0, 16'h0200, 16'h0000, 99, 16'h0000, 6, 5, 0, 0, 1, 16'h0F0F});
        tbl.push_back('{"acklim", 0, 0, 16'h0204, 16'h0000, 4, 16'h7777, 6, 5, 0, 1, 0, 16'h7777});
`else
        tbl.push_back('{"longwait", 0, 0, 16'h0200, 16'h0000, 30, 16'h7777, 32, 31, 0, 1, 0, 16'h7777});
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst req_ready", req_ready, 1);
        chk("rst outs", {mem_rd, mem_wr, mar_en, mdr_en, ir_en, rsp_valid, rsp_err}, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst rsp_data", rsp_data, 0);

        // Ack while idle must be ignored.
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        repeat (2) begin
            @(negedge clk);
            chk("idle_ack outs", {req_ready, mem_rd, mem_wr, mar_en, mdr_en, ir_en, rsp_valid, rsp_err}, 8'h80);
            chk("idle_ack rsp_data", rsp_data, 0);
            chk("idle_ack mem_addr", mem_addr, 0);
        end
        mem_ack = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i]);

        // Back-to-back with req_valid held and address changed mid-access.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_fetch = 1'b0; req_addr = 16'h0A0A;
        @(posedge clk);
        @(negedge clk);
        chk("b2b c1 mar_en", mar_en, 1);
        chk("b2b c1 ready", req_ready, 0);
        @(negedge clk);
        req_addr = 16'h0B0B; mem_ack = 1'b1; mem_rdata = 16'h1111;
        chk("b2b c2 mem_addr", mem_addr, 16'h0A0A);
        chk("b2b c2 ready", req_ready, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b c3 rsp_valid", rsp_valid, 1);
        chk("b2b c3 rsp_data", rsp_data, 16'h1111);
        chk("b2b c3 mem_addr", mem_addr, 16'h0A0A);
        chk("b2b c3 ready", req_ready, 0);
        @(negedge clk);
        chk("b2b c4 ready", req_ready, 1);
        chk("b2b c4 rsp_valid", rsp_valid, 0);
        @(negedge clk);
        req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h2222;
        chk("b2b c5 mar_en", mar_en, 1);
        chk("b2b c5 mem_addr", mem_addr, 16'h0B0B);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b c6 rsp_valid", rsp_valid, 1);
        chk("b2b c6 rsp_data", rsp_data, 16'h2222);
        chk("b2b c6 mdr_en", mdr_en, 1);

        // Reset while a load sits in WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0300;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstwait in_wait mem_rd", mem_rd, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstwait mem_rd", mem_rd, 0);
        chk("rstwait ready", req_ready, 1);
        chk("rstwait mem_addr", mem_addr, 0);
        chk("rstwait rsp_data", rsp_data, 0);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        chk("rstwait no rsp_valid", pulses, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter DATA_BUS_WIDTH, default 16, sets the width of the data and instruction paths.
REQ-002 Parameter ADDRESS_BUS_WIDTH, default 16, sets the width of the address path.
REQ-003 Parameter TIMEOUT_CYCLES, default 15, sets the maximum number of cycles spent waiting for mem_ack; legal range 1..255.
REQ-004 The block SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  block idle; request accepted when req_valid && req_ready at a rising edge.
REQ-009 req_write  in  1  1 = store, 0 = load.
REQ-010 req_fetch  in  1  load is an instruction fetch; ignored when req_write=1.
REQ-011 req_addr  in  ADDRESS_BUS_WIDTH  access address.
REQ-012 req_wdata  in  DATA_BUS_WIDTH  store data.
REQ-013 mem_addr  out  ADDRESS_BUS_WIDTH  registered address to memory.
REQ-014 mem_wdata  out  DATA_BUS_WIDTH  registered store data.
REQ-015 mem_rd / mem_wr  out  1 each  read / write strobes; never both high.
REQ-016 mem_rdata  in  DATA_BUS_WIDTH  read data, valid when mem_ack=1.
REQ-017 mem_ack  in  1  memory completion.
REQ-018 mar_en / mdr_en / ir_en  out  1 each  one-cycle load enables for the external address, data and instruction registers.
REQ-019 rsp_data  out  DATA_BUS_WIDTH  captured read data, held until the next capture.
REQ-020 rsp_valid  out  1  one-cycle completion pulse.
REQ-021 rsp_err  out  1  completion was a timeout; qualified by rsp_valid.

Function
REQ-022 FSM states: IDLE, ADDR, WAIT, DONE.
REQ-023 IDLE: req_ready=1; on accept, latch addr, wdata, write and fetch into mem_addr, mem_wdata and internal flags; go to ADDR.
REQ-024 ADDR: mar_en=1 for this cycle only; assert mem_rd or mem_wr according to the latched write flag; clear the timeout counter.
REQ-025 ADDR and WAIT: strobe held high; mem_ack sampled in both states; on mem_ack capture mem_rdata into rsp_data (loads only) and go to DONE.
REQ-026 ADDR without mem_ack goes to WAIT; WAIT increments the counter each cycle without mem_ack.
REQ-027 DONE: strobes low; rsp_valid=1; for a successful load, ir_en=1 if fetch else mdr_en=1; a store pulses neither; next state IDLE.
REQ-028 Minimum latency: accept edge -> rsp_valid high 2 cycles later (ack in ADDR); each extra cycle of ack delay adds 1.
REQ-029 mem_addr, mem_wdata and the latched flags SHALL NOT change between accept and return to IDLE; req_* changes are ignored outside IDLE.
REQ-030 req_ready=0 in ADDR, WAIT and DONE; a request held across DONE is accepted in the following IDLE cycle (back-to-back throughput of one access per 3+ cycles).
REQ-031 mem_ack in IDLE or DONE is ignored.

Reset
REQ-032 rst at any clock edge, including mid-access, SHALL force IDLE and drop the strobes on the next cycle; no rsp_valid is issued for the aborted access.
REQ-033 Reset values: mem_addr=0, mem_wdata=0, rsp_data=0, timeout counter=0; mem_rd, mem_wr, mar_en, mdr_en, ir_en, rsp_valid and rsp_err=0; req_ready=1 after reset releases.

Configuration
REQ-034 Macro MEM_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYCLES in WAIT without mem_ack, go to DONE with rsp_err=1, rsp_data unchanged and no mdr_en or ir_en; mem_ack in the same cycle wins, giving rsp_err=0.
REQ-035 MEM_TIMEOUT_EN undefined: no counter logic; WAIT holds indefinitely until mem_ack; rsp_err is tied to 0.

Verification
REQ-036 Fetch at 0x0040, mem_ack in ADDR with mem_rdata=0xA5A5 -> mar_en at cycle+1, rsp_valid, ir_en=1 and rsp_data=0xA5A5 at cycle+2, mdr_en=0.
REQ-037 Store 0x1234 to 0x00FF, ack after 3 WAIT cycles -> mem_wr high for 4 cycles, mem_wdata=0x1234, rsp_valid=1, no mdr_en or ir_en.
REQ-038 Load with MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> rsp_err=1 with rsp_valid; rsp_data keeps its previous value; then ack arriving on the limit cycle -> rsp_err=0, mdr_en=1.
REQ-039 rst asserted in WAIT of a load -> next cycle IDLE, mem_rd=0, req_ready=1; no rsp_valid pulse follows.
REQ-040 req_valid held high through two loads with req_addr changed during WAIT -> mem_addr is stable per access; second accept occurs on the IDLE cycle after DONE.
REQ-041 mem_ack pulsed while IDLE -> no state change; all outputs remain at their reset values.
